dual_port_sync_ram: RTL and testbench
=====================================

# dual_port_sync_ram

Parametrised simple-dual-port synchronous RAM: one write port and one read port, sharing a single clock. It replaces the single-port tri-state data RAM for traffic-controller state and timing tables. It adds:
- byte-enable writes and a registered read with a valid strobe;
- a defined read-during-write policy and out-of-range address flagging;
- a self-clearing initialisation sequence after reset, so table contents are known before the controller starts.

## Interface
- ADDR_WIDTH, 4, address width of both ports
- DATA_WIDTH, 16, word width; must be a multiple of BYTE_WIDTH
- BYTE_WIDTH, 8, bits covered by one wr_be bit
- DEPTH, 16, number of words; 1 ≤ DEPTH ≤ 2**ADDR_WIDTH
- RDW_MODE, 0, same-address read/write in one cycle: 0 = read returns old data, 1 = read returns new (merged) data
- clk  input  1  clock; all logic on posedge
- rst_n  input  1  asynchronous, active-low reset
- wr_en  input  1  write request
- wr_addr  input  ADDR_WIDTH  write address
- wr_data  input  DATA_WIDTH  write data
- wr_be  input  DATA_WIDTH/BYTE_WIDTH  byte enables; bit i covers wr_data[i*BYTE_WIDTH +: BYTE_WIDTH]
- rd_req  input  1  read request
- rd_addr  input  ADDR_WIDTH  read address
- init_done  output  1  clear sequence complete; both ports accept requests
- rd_valid  output  1  one-cycle strobe; rd_data valid
- rd_data  output  DATA_WIDTH  read data; holds last value when rd_valid is low
- rd_err  output  1  parity error on this read, qualified by rd_valid
- addr_err  output  1  one-cycle pulse; a request used an address ≥ DEPTH
- wr_perr_inj  input  1  present only with RAM_PARITY_EN; inverts the stored parity of the accepted write

## Operation
- FSM states: CLEAR, RUN. rst_n low forces CLEAR with clear counter = 0.
- CLEAR:
  - writes all-zero data (and correct parity) to address = counter, one word per cycle;
  - counter increments each cycle; after address DEPTH-1 is written, the FSM moves to RUN;
  - wr_en and rd_req are ignored, not queued.
- RUN: init_done = 1. A write is accepted when wr_en = 1. A read is accepted when rd_req = 1. Both can be accepted in the same cycle.
- Write: only bytes with wr_be[i] = 1 are updated. wr_be = 0 is a legal no-op.
- Read: the word at rd_addr is registered. rd_valid and rd_data update on the next edge.
- Same-address read and write in one cycle:
  - RDW_MODE 0: rd_data = pre-write word;
  - RDW_MODE 1: rd_data = stored word with the enabled bytes replaced by wr_data.
- Out-of-range address (≥ DEPTH, only possible when DEPTH < 2**ADDR_WIDTH):
  - write is dropped;
  - read still gives rd_valid, with rd_data = 0 and rd_err = 0;
  - addr_err pulses on the following cycle. It pulses once, even if both ports are out of range.
- Memory array has no reset. Contents are defined only by the clear sequence and by subsequent writes.

## Timing
- Reset values: init_done 0, rd_valid 0, rd_data 0, rd_err 0, addr_err 0, state CLEAR.
- The clear sequence starts at the first posedge after rst_n deasserts. It takes exactly DEPTH cycles. init_done rises at the DEPTH-th edge.
- Write latency: a write accepted at edge N is readable by a read accepted at edge N+1. At edge N itself, RDW_MODE applies.
- Read latency: 1 cycle. A request at edge N gives rd_valid = 1 and rd_data during cycle N+1 → N+2.
- Back-to-back reads every cycle give rd_valid continuously high.
- Reset mid-operation (including mid-clear): outputs return to reset values immediately (asynchronous). Any in-flight read is discarded. The clear sequence restarts from address 0.

## Configuration
- RAM_PARITY_EN defined:
  - one even-parity bit is stored per byte and updated with its byte enable;
  - the read path recomputes parity; rd_err = 1 with rd_valid if any byte mismatches;
  - the wr_perr_inj port exists.
- RAM_PARITY_EN undefined: no parity storage, rd_err is tied to 0, and the wr_perr_inj port is absent.

## Structure
- Package ram_pkg: state enum (CLEAR, RUN) and RDW_MODE constants (RDW_OLD = 0, RDW_NEW = 1).
- Sub-module ram_clear_seq: the CLEAR/RUN FSM and address counter. Outputs clear_we, clear_addr, init_done.
- Top level: write-port mux (clear vs. user), byte-merge logic, memory array, read register, optional parity.

## Test plan
- Reset release, DEPTH = 16: init_done rises exactly 16 cycles later. Reading every address returns 0x0000. A rd_req issued during CLEAR produces no rd_valid.
- Write 0xABCD to address 3 with wr_be = 2'b01, then read address 3 → rd_data = 0x00CD, with rd_valid one cycle after the request.
- Write 0x1234 to address 5 with full wr_be while reading address 5 in the same cycle → rd_data = 0x0000 for RDW_MODE 0, or 0x1234 for RDW_MODE 1.
- DEPTH = 12: write to address 14 → addr_err pulses once. A following read of address 14 → rd_valid with rd_data = 0. Words 0–11 are unchanged.
- Assert rst_n low mid-clear (cycle 7) and mid-read: all outputs go to 0 immediately. After release, CLEAR takes the full 16 cycles again.
- RAM_PARITY_EN: write 0x00FF with wr_perr_inj = 1, then read → rd_err = 1 with rd_valid. Rewrite with wr_perr_inj = 0 and read → rd_err = 0.

Source files
------------

// File: rtl/ram_pkg.sv
// Shared types and constants for the dual-port synchronous RAM.
package ram_pkg;

  typedef enum logic [0:0] {
    StClear,
    StRun
  } ram_state_e;

  localparam int unsigned RDW_OLD = 0;
  localparam int unsigned RDW_NEW = 1;

endpackage

// File: rtl/ram_clear_seq.sv
// Post-reset clear sequencer: walks every address once writing zero, then enables user access.
module ram_clear_seq
  import ram_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = 4,
  parameter int unsigned DEPTH      = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  output logic                  clear_we,
  output logic [ADDR_WIDTH-1:0] clear_addr,
  output logic                  init_done
);

  ram_state_e            state_q;
  logic [ADDR_WIDTH-1:0] cnt_q;
  logic                  init_done_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StClear;
      cnt_q       <= '0;
      init_done_q <= 1'b0;
    end else begin
      unique case (state_q)
        StClear: begin
          if (cnt_q == ADDR_WIDTH'(DEPTH - 1)) begin
            state_q     <= StRun;
            cnt_q       <= '0;
            init_done_q <= 1'b1;
          end else begin
            cnt_q <= cnt_q + ADDR_WIDTH'(1);
          end
        end
        StRun: begin
          init_done_q <= 1'b1;
        end
        default: begin
          state_q <= StClear;
        end
      endcase
    end
  end

  assign clear_we   = (state_q == StClear);
  assign clear_addr = cnt_q;
  assign init_done  = init_done_q;

endmodule

// File: rtl/dual_port_sync_ram.sv
// Simple-dual-port RAM with byte enables, registered read and post-reset clear.
// Optional per-byte even parity when RAM_PARITY_EN is defined.
module dual_port_sync_ram
  import ram_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = 4,
  parameter int unsigned DATA_WIDTH = 16,
  parameter int unsigned BYTE_WIDTH = 8,
  parameter int unsigned DEPTH      = 16,
  parameter int unsigned RDW_MODE   = 0
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic                             wr_en,
  input  logic [ADDR_WIDTH-1:0]            wr_addr,
  input  logic [DATA_WIDTH-1:0]            wr_data,
  input  logic [DATA_WIDTH/BYTE_WIDTH-1:0] wr_be,
  input  logic                             rd_req,
  input  logic [ADDR_WIDTH-1:0]            rd_addr,
  output logic                             init_done,
  output logic                             rd_valid,
  output logic [DATA_WIDTH-1:0]            rd_data,
  output logic                             rd_err,
  output logic                             addr_err
`ifdef RAM_PARITY_EN
  ,
  input  logic                             wr_perr_inj
`endif
);

  localparam int unsigned NB = DATA_WIDTH / BYTE_WIDTH;

  logic                  clear_we;
  logic [ADDR_WIDTH-1:0] clear_addr;

  ram_clear_seq #(
    .ADDR_WIDTH(ADDR_WIDTH),
    .DEPTH     (DEPTH)
  ) u_clear_seq (
    .clk       (clk),
    .rst_n     (rst_n),
    .clear_we  (clear_we),
    .clear_addr(clear_addr),
    .init_done (init_done)
  );

  logic wr_oor, rd_oor, wr_acc, rd_acc, rdw_hit;

  assign wr_oor  = 32'(wr_addr) >= DEPTH;
  assign rd_oor  = 32'(rd_addr) >= DEPTH;
  assign wr_acc  = init_done & wr_en & ~wr_oor;
  assign rd_acc  = init_done & rd_req;
  assign rdw_hit = wr_acc && (wr_addr == rd_addr);

  // Clear sequencer owns the write port until init_done.
  logic                  mem_we;
  logic [ADDR_WIDTH-1:0] mem_waddr;
  logic [DATA_WIDTH-1:0] mem_wdata;
  logic [NB-1:0]         mem_be;

  assign mem_we    = clear_we | wr_acc;
  assign mem_waddr = clear_we ? clear_addr : wr_addr;
  assign mem_wdata = clear_we ? '0 : wr_data;
  assign mem_be    = clear_we ? '1 : wr_be;

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (mem_we) begin
      for (int i = 0; i < NB; i++) begin
        if (mem_be[i]) mem[mem_waddr][i*BYTE_WIDTH +: BYTE_WIDTH] <=
            mem_wdata[i*BYTE_WIDTH +: BYTE_WIDTH];
      end
    end
  end

  logic [DATA_WIDTH-1:0] rd_next;
  logic                  rd_mis;

  always_comb begin
    rd_next = rd_oor ? '0 : mem[rd_addr];
    if (RDW_MODE == RDW_NEW && rdw_hit) begin
      for (int i = 0; i < NB; i++) begin
        if (wr_be[i]) rd_next[i*BYTE_WIDTH +: BYTE_WIDTH] = wr_data[i*BYTE_WIDTH +: BYTE_WIDTH];
      end
    end
  end

`ifdef RAM_PARITY_EN
  logic [NB-1:0] par_mem [DEPTH];
  logic          par_inj;
  logic [NB-1:0] rd_par;

  assign par_inj = ~clear_we & wr_perr_inj;

  always_ff @(posedge clk) begin
    if (mem_we) begin
      for (int i = 0; i < NB; i++) begin
        if (mem_be[i]) par_mem[mem_waddr][i] <= (^mem_wdata[i*BYTE_WIDTH +: BYTE_WIDTH]) ^ par_inj;
      end
    end
  end

  always_comb begin
    rd_par = rd_oor ? '0 : par_mem[rd_addr];
    if (RDW_MODE == RDW_NEW && rdw_hit) begin
      for (int i = 0; i < NB; i++) begin
        if (wr_be[i]) rd_par[i] = (^wr_data[i*BYTE_WIDTH +: BYTE_WIDTH]) ^ wr_perr_inj;
      end
    end
    rd_mis = 1'b0;
    for (int i = 0; i < NB; i++) begin
      if ((^rd_next[i*BYTE_WIDTH +: BYTE_WIDTH]) != rd_par[i]) rd_mis = 1'b1;
    end
  end
`else
  assign rd_mis = 1'b0;
`endif

  logic                  rd_valid_q, rd_err_q, addr_err_q;
  logic [DATA_WIDTH-1:0] rd_data_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_valid_q <= 1'b0;
      rd_data_q  <= '0;
      rd_err_q   <= 1'b0;
      addr_err_q <= 1'b0;
    end else begin
      rd_valid_q <= rd_acc;
      rd_err_q   <= rd_acc & rd_mis;
      if (rd_acc) rd_data_q <= rd_next;
      // One pulse even when both ports are out of range.
      addr_err_q <= init_done & ((wr_en & wr_oor) | (rd_req & rd_oor));
    end
  end

  assign rd_valid = rd_valid_q;
  assign rd_data  = rd_data_q;
  assign rd_err   = rd_err_q;
  assign addr_err = addr_err_q;

endmodule

// File: tb/tb_dual_port_sync_ram.sv
// Directed bench: instance a (DEPTH 16, old-data RDW) and b (DEPTH 12, new-data RDW) share stimulus.
module tb_dual_port_sync_ram;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        wr_en = 1'b0;
  logic [3:0]  wr_addr = '0;
  logic [15:0] wr_data = '0;
  logic [1:0]  wr_be = '0;
  logic        rd_req = 1'b0;
  logic [3:0]  rd_addr = '0;
  logic        wr_perr_inj = 1'b0;

  logic        init_a, vld_a, err_a, aerr_a;
  logic [15:0] data_a;
  logic        init_b, vld_b, err_b, aerr_b;
  logic [15:0] data_b;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  dual_port_sync_ram u_a (
    .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .wr_be(wr_be), .rd_req(rd_req), .rd_addr(rd_addr), .init_done(init_a),
    .rd_valid(vld_a), .rd_data(data_a), .rd_err(err_a), .addr_err(aerr_a)
`ifdef RAM_PARITY_EN
    , .wr_perr_inj(wr_perr_inj)
`endif
  );

  dual_port_sync_ram #(.DEPTH(12), .RDW_MODE(1)) u_b (
    .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .wr_be(wr_be), .rd_req(rd_req), .rd_addr(rd_addr), .init_done(init_b),
    .rd_valid(vld_b), .rd_data(data_b), .rd_err(err_b), .addr_err(aerr_b)
`ifdef RAM_PARITY_EN
    , .wr_perr_inj(wr_perr_inj)
`endif
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    wr_en = 1'b0; rd_req = 1'b0; wr_perr_inj = 1'b0;
  endtask

  // Release reset and count edges until each instance reports init_done.
  task automatic release_and_count(input bit chk_valid);
    int rise_a = 0;
    int rise_b = 0;
    bit any_vld = 1'b0;
    rst_n = 1'b1;
    for (int i = 1; i <= 20; i++) begin
      step();
      if (init_a && rise_a == 0) rise_a = i;
      if (init_b && rise_b == 0) rise_b = i;
      if (i <= 16 && vld_a) any_vld = 1'b1;
    end
    check("init_rise_a", rise_a, 16);
    check("init_rise_b", rise_b, 12);
    if (chk_valid) check("no_valid_in_clear", any_vld, 0);
    idle();
    step();
  endtask

  task automatic wr(input logic [3:0] a, input logic [15:0] d, input logic [1:0] be);
    wr_en = 1'b1; wr_addr = a; wr_data = d; wr_be = be;
  endtask

  task automatic rd(input logic [3:0] a);
    rd_req = 1'b1; rd_addr = a;
  endtask

  logic [15:0] exp_b [12];

  initial begin
    #2;
    check("rst_init", init_a, 0);
    check("rst_valid", vld_a, 0);
    check("rst_data", data_a, 0);
    check("rst_aerr", aerr_a, 0);
    step();
    step();

    // Read request held through CLEAR must not produce rd_valid.
    rd(4'd0);
    release_and_count(1'b1);

    for (int i = 0; i < 16; i++) begin
      rd(4'(i));
      step();
      check("clr_vld", vld_a, 1);
      check("clr_data", data_a, 16'h0000);
    end
    idle();
    step();
    check("vld_drop", vld_a, 0);

    wr(4'd3, 16'hABCD, 2'b01);
    step();
    idle();
    check("vld_after_wr", vld_a, 0);
    rd(4'd3);
    step();
    idle();
    check("be_vld_a", vld_a, 1);
    check("be_data_a", data_a, 16'h00CD);
    check("be_data_b", data_b, 16'h00CD);
    step();
    check("vld_strobe", vld_a, 0);
    check("data_hold", data_a, 16'h00CD);

    wr(4'd5, 16'h1234, 2'b11);
    rd(4'd5);
    step();
    idle();
    check("rdw_old_a", data_a, 16'h0000);
    check("rdw_new_b", data_b, 16'h1234);
    wr(4'd3, 16'h5511, 2'b10);
    rd(4'd3);
    step();
    idle();
    check("rdw_merge_a", data_a, 16'h00CD);
    check("rdw_merge_b", data_b, 16'h55CD);
    rd(4'd5);
    step();
    idle();
    check("post_rdw_a", data_a, 16'h1234);
    check("post_rdw_b", data_b, 16'h1234);

    wr(4'd14, 16'hFFFF, 2'b11);
    step();
    idle();
    check("oor_aerr_b", aerr_b, 1);
    check("oor_aerr_a", aerr_a, 0);
    step();
    check("oor_pulse_once", aerr_b, 0);
    wr(4'd15, 16'hFFFF, 2'b11);
    rd(4'd14);
    step();
    idle();
    check("oor_both_aerr", aerr_b, 1);
    check("oor_rd_vld", vld_b, 1);
    check("oor_rd_data", data_b, 16'h0000);
    check("oor_rd_err", err_b, 0);
    check("inrange_a", data_a, 16'hFFFF);
    step();
    check("oor_both_once", aerr_b, 0);

    for (int i = 0; i < 12; i++) exp_b[i] = 16'h0000;
    exp_b[3] = 16'h55CD;
    exp_b[5] = 16'h1234;
    for (int i = 0; i < 12; i++) begin
      rd(4'(i));
      step();
      check("b_unchanged", data_b, exp_b[i]);
    end
    idle();
    step();

`ifdef RAM_PARITY_EN
    wr(4'd2, 16'h00FF, 2'b11);
    wr_perr_inj = 1'b1;
    step();
    idle();
    rd(4'd2);
    step();
    idle();
    check("perr_vld", vld_a, 1);
    check("perr_a", err_a, 1);
    check("perr_b", err_b, 1);
    wr(4'd2, 16'h00FF, 2'b11);
    step();
    idle();
    rd(4'd2);
    step();
    idle();
    check("perr_clr_a", err_a, 0);
    check("perr_clr_b", err_b, 0);
    step();
`endif

    // Reset during an in-flight read.
    rd(4'd3);
    step();
    idle();
    check("pre_rst_vld", vld_a, 1);
    rst_n = 1'b0;
    #1;
    check("mid_rd_vld", vld_a, 0);
    check("mid_rd_data", data_a, 0);
    check("mid_rd_init", init_a, 0);
    step();
    release_and_count(1'b0);

    // Reset seven cycles into CLEAR.
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    for (int i = 0; i < 7; i++) step();
    rst_n = 1'b0;
    #1;
    check("mid_clr_init", init_a, 0);
    check("mid_clr_aerr", aerr_a, 0);
    step();
    release_and_count(1'b0);
    rd(4'd3);
    step();
    idle();
    check("recleared_a", data_a, 16'h0000);
    check("recleared_b", data_b, 16'h0000);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
